// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with a standard registered-read mode or a first-word-fall-through
// mode. It provides occupancy count, almost-full/empty thresholds and overflow/underflow pulses.
module sync_fifo_fwft #(
  parameter int data_width = 16,
  parameter int addr_width = 5,
  parameter bit fwft       = 1'b0,
  parameter int af_level   = (1 << addr_width) - 4,
  parameter int ae_level   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] din,
  input  logic                  rd_en,
  output logic [data_width-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int depth = 1 << addr_width;
  localparam logic [addr_width:0] depth_c = (addr_width + 1)'(depth);
  localparam logic [addr_width:0] af_c    = (addr_width + 1)'(af_level);
  localparam logic [addr_width:0] ae_c    = (addr_width + 1)'(ae_level);

  logic [data_width-1:0] mem [depth];

  logic [addr_width:0]   wr_ptr_q, wr_ptr_d;
  logic [addr_width:0]   rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_wr;
  logic                  mem_rd;

  logic [addr_width-1:0] wr_addr;
  logic [addr_width-1:0] rd_addr;

  assign wr_addr = wr_ptr_q[addr_width-1:0];
  assign rd_addr = rd_ptr_q[addr_width-1:0];
  assign wr_acc  = wr_en & ~full_q;

  generate
    if (fwft) begin : g_fwft
      // The output register holds the head word, so storage holds count-valid words.
      logic mem_has_data;
      logic refill;

      assign rd_acc       = rd_en & valid_q;
      assign mem_has_data = count_q > {{addr_width{1'b0}}, valid_q};
      assign refill       = ~valid_q | rd_acc;

      always_comb begin
        mem_wr  = wr_acc;
        mem_rd  = 1'b0;
        dout_d  = dout_q;
        valid_d = valid_q;
        if (refill) begin
          if (mem_has_data) begin
            mem_rd  = 1'b1;
            dout_d  = mem[rd_addr];
            valid_d = 1'b1;
          end else if (wr_acc) begin
            // Bypass: the incoming word goes straight to the output register.
            mem_wr  = 1'b0;
            dout_d  = din;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
    end else begin : g_std
      assign rd_acc = rd_en & ~empty_q;

      always_comb begin
        mem_wr  = wr_acc;
        mem_rd  = rd_acc;
        dout_d  = dout_q;
        valid_d = rd_acc;
        if (rd_acc) begin
          dout_d = mem[rd_addr];
        end
      end
    end
  endgenerate

  always_comb begin
    wr_ptr_d       = wr_ptr_q + {{addr_width{1'b0}}, mem_wr};
    rd_ptr_d       = rd_ptr_q + {{addr_width{1'b0}}, mem_rd};
    count_d        = count_q + {{addr_width{1'b0}}, wr_acc} - {{addr_width{1'b0}}, rd_acc};
    full_d         = (count_d == depth_c);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= af_c);
    almost_empty_d = (count_d <= ae_c);
    overflow_d     = wr_en & full_q;
    underflow_d    = rd_en & empty_q;
  end

  // Storage is deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dout_q         <= '0;
      valid_q        <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      dout_q         <= dout_d;
      valid_q        <= valid_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
